// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared definitions for the multi-cycle RV32I core: sequencer states,
// base opcodes, instruction classes, datapath select encodings and the bundle
// of control outputs produced by the sequencer each cycle.
// -----------------------------------------------------------------------------
package core_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    // RV32I base opcodes (instr[6:0])
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Instruction classes the sequencer distinguishes
    typedef enum logic [3:0] {
        CLS_OP     = 4'd0,
        CLS_OPIMM  = 4'd1,
        CLS_LOAD   = 4'd2,
        CLS_STORE  = 4'd3,
        CLS_BRANCH = 4'd4,
        CLS_LUI    = 4'd5,
        CLS_AUIPC  = 4'd6,
        CLS_JAL    = 4'd7,
        CLS_JALR   = 4'd8
    } instr_class_t;

    // Immediate-format select, shared with the immediate generator
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    // Next-PC select
    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_IMM   = 2'b01;
    localparam logic [1:0] PC_ALU   = 2'b10;

    // Register-file write-back select
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    // ALU operand selects
    localparam logic [1:0] ASRC_RS1  = 2'b00;
    localparam logic [1:0] ASRC_PC   = 2'b01;
    localparam logic [1:0] ASRC_ZERO = 2'b10;
    localparam logic       BSRC_RS2  = 1'b0;
    localparam logic       BSRC_IMM  = 1'b1;

    // ALU operation
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_FUNCT = 2'b01;
    localparam logic [1:0] ALU_CMP   = 2'b10;

    // All control outputs of the sequencer
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       addr_sel;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic [2:0] imm_sel;
        logic [1:0] alu_src_a;
        logic       alu_src_b;
        logic [1:0] alu_op;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic       trap;
    } ctrl_t;

    // Immediate format used by each instruction class (OP has none; I is harmless)
    function automatic logic [2:0] imm_sel_of(input instr_class_t cls);
        case (cls)
            CLS_STORE:         return IMM_S;
            CLS_BRANCH:        return IMM_B;
            CLS_LUI, CLS_AUIPC: return IMM_U;
            CLS_JAL:           return IMM_J;
            default:           return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/opcode_classifier.sv
// -----------------------------------------------------------------------------
// opcode_classifier
// Combinational map from the 7-bit opcode to an instruction class plus an
// illegal flag for anything outside the supported RV32I subset.
//   i_opcode   in   7  instr[6:0]
//   o_class    out  4  instruction class (CLS_OP when illegal)
//   o_illegal  out  1  opcode not recognised, or instr[1:0] != 2'b11
// -----------------------------------------------------------------------------
module opcode_classifier
    import core_pkg::*;
(
    input  logic [6:0]   i_opcode,
    output instr_class_t o_class,
    output logic         o_illegal
);

    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        o_class   = CLS_OP;
        o_illegal = 1'b0;
        case (i_opcode)
            OPC_OP:     o_class = CLS_OP;
            OPC_OPIMM:  o_class = CLS_OPIMM;
            OPC_LOAD:   o_class = CLS_LOAD;
            OPC_STORE:  o_class = CLS_STORE;
            OPC_BRANCH: o_class = CLS_BRANCH;
            OPC_LUI:    o_class = CLS_LUI;
            OPC_AUIPC:  o_class = CLS_AUIPC;
            OPC_JAL:    o_class = CLS_JAL;
            OPC_JALR:   o_class = CLS_JALR;
            default:    o_illegal = 1'b1;
        endcase
        // Compressed encodings are not supported (all listed opcodes end in 11).
        if (i_opcode[1:0] != 2'b11) begin
            o_illegal = 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Control sequencer for the multi-cycle RV32I core. Steps each instruction
// through FETCH, DECODE, EXEC, MEM and WB, drives every datapath enable and
// select, owns the memory request handshake with a wait-state timeout, traps
// on illegal opcodes and counts retired instructions.
//   clk        in   1   core clock, rising edge
//   rst        in   1   synchronous reset, active-high
//   instr      in   32  instruction register output (valid DECODE..next FETCH)
//   mem_ready  in   1   memory completes the current request this cycle
//   br_taken   in   1   branch comparator result, valid in EXEC
//   mem_req    out  1   memory access request
//   mem_we     out  1   1 = store, 0 = read
//   addr_sel   out  1   memory address: 0 = PC, 1 = ALU result
//   ir_we      out  1   load instruction register
//   pc_we      out  1   update PC (marks retirement)
//   pc_sel     out  2   next PC select
//   imm_sel    out  3   immediate format select
//   alu_src_a  out  2   ALU operand A select
//   alu_src_b  out  1   ALU operand B select
//   alu_op     out  2   ALU operation
//   rf_we      out  1   register-file write
//   wb_sel     out  2   write-back source select
//   trap       out  1   sticky illegal-opcode / timeout indication
//   instret    out  32  retired-instruction count
// -----------------------------------------------------------------------------
module multicycle_ctrl
    import core_pkg::*;
#(
    parameter int unsigned TIMEOUT   = 16,      // 2..255
    parameter logic [31:0] RESET_CNT = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        br_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic [2:0]  imm_sel,
    output logic [1:0]  alu_src_a,
    output logic        alu_src_b,
    output logic [1:0]  alu_op,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        trap,
    output logic [31:0] instret
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t       r_state;
    state_t       w_state_next;
    logic [7:0]   r_wait_cnt;
    instr_class_t r_cls;
    logic [31:0]  r_instret;

    instr_class_t w_cls;
    logic         w_illegal;
    logic         w_wait_expired;
    ctrl_t        w_ctrl;

    // The upper instruction bits feed the datapath, not the sequencer.
    logic w_unused_instr;
    assign w_unused_instr = ^instr[31:7];

    opcode_classifier u_classifier (
        .i_opcode  (instr[6:0]),
        .o_class   (w_cls),
        .o_illegal (w_illegal)
    );

    // A request still unanswered on its TIMEOUT-th cycle traps, unless
    // mem_ready arrives in that same cycle.
    assign w_wait_expired = (r_wait_cnt == WAIT_LAST);

    // ---------------------------------------------------------------- state
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= FETCH;
            r_wait_cnt <= 8'd0;
            r_cls      <= CLS_OP;
            r_instret  <= RESET_CNT;
        end else begin
            r_state <= w_state_next;

            // Cleared on every state change, so it starts at 0 on entry to
            // FETCH or MEM and counts only unanswered request cycles.
            if (w_state_next != r_state) begin
                r_wait_cnt <= 8'd0;
            end else if ((r_state == FETCH || r_state == MEM) && !mem_ready) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end

            // The class is captured once and steers the rest of the instruction.
            if (r_state == DECODE) begin
                r_cls <= w_cls;
            end

            // pc_we is asserted exactly in the cycle an instruction retires.
            if (w_ctrl.pc_we) begin
                r_instret <= r_instret + 32'd1;
            end
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FETCH: begin
                if (mem_ready)           w_state_next = DECODE;
                else if (w_wait_expired) w_state_next = TRAP;
            end
            DECODE: begin
                w_state_next = w_illegal ? TRAP : EXEC;
            end
            EXEC: begin
                case (r_cls)
                    CLS_LOAD, CLS_STORE: w_state_next = MEM;
                    CLS_BRANCH:          w_state_next = FETCH;
                    default:             w_state_next = WB;
                endcase
            end
            MEM: begin
                if (mem_ready)           w_state_next = (r_cls == CLS_LOAD) ? WB : FETCH;
                else if (w_wait_expired) w_state_next = TRAP;
            end
            WB:      w_state_next = FETCH;
            TRAP:    w_state_next = TRAP;
            default: w_state_next = FETCH;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        w_ctrl = '0;
        case (r_state)
            FETCH: begin
                w_ctrl.mem_req = 1'b1;
                w_ctrl.ir_we   = mem_ready;
            end
            DECODE: begin
                // The class register is not loaded yet; use the live opcode.
                w_ctrl.imm_sel = imm_sel_of(w_cls);
            end
            EXEC, MEM, WB: begin
                // Operand selects stay put after EXEC so the ALU result keeps
                // feeding the address mux (MEM) and write-back / PC (WB).
                w_ctrl.imm_sel   = imm_sel_of(r_cls);
                w_ctrl.alu_src_a = ASRC_RS1;
                w_ctrl.alu_src_b = BSRC_IMM;
                w_ctrl.alu_op    = ALU_ADD;
                case (r_cls)
                    CLS_OP:     begin w_ctrl.alu_src_b = BSRC_RS2; w_ctrl.alu_op = ALU_FUNCT; end
                    CLS_OPIMM:  w_ctrl.alu_op = ALU_FUNCT;
                    CLS_BRANCH: begin w_ctrl.alu_src_b = BSRC_RS2; w_ctrl.alu_op = ALU_CMP; end
                    CLS_LUI:    w_ctrl.alu_src_a = ASRC_ZERO;
                    CLS_AUIPC,
                    CLS_JAL:    w_ctrl.alu_src_a = ASRC_PC;
                    default:    ;
                endcase

                if (r_state == EXEC && r_cls == CLS_BRANCH) begin
                    // Taken or not, the branch retires here; only the target differs.
                    w_ctrl.pc_we  = 1'b1;
                    w_ctrl.pc_sel = br_taken ? PC_IMM : PC_PLUS4;
                end

                if (r_state == MEM) begin
                    w_ctrl.mem_req  = 1'b1;
                    w_ctrl.addr_sel = 1'b1;
                    if (r_cls == CLS_STORE) begin
                        w_ctrl.mem_we = 1'b1;
                        w_ctrl.pc_we  = mem_ready;
                        w_ctrl.pc_sel = PC_PLUS4;
                    end
                end

                if (r_state == WB) begin
                    w_ctrl.rf_we = 1'b1;
                    w_ctrl.pc_we = 1'b1;
                    case (r_cls)
                        CLS_LOAD: w_ctrl.wb_sel = WB_MEM;
                        CLS_JAL:  begin w_ctrl.wb_sel = WB_PC4; w_ctrl.pc_sel = PC_IMM; end
                        CLS_JALR: begin w_ctrl.wb_sel = WB_PC4; w_ctrl.pc_sel = PC_ALU; end
                        default:  ;
                    endcase
                end
            end
            TRAP:    w_ctrl.trap = 1'b1;
            default: ;
        endcase

        // Reset silences everything in the same cycle, including an
        // outstanding mem_req; the memory must abandon that request.
        if (rst) begin
            w_ctrl = '0;
        end
    end

    assign mem_req   = w_ctrl.mem_req;
    assign mem_we    = w_ctrl.mem_we;
    assign addr_sel  = w_ctrl.addr_sel;
    assign ir_we     = w_ctrl.ir_we;
    assign pc_we     = w_ctrl.pc_we;
    assign pc_sel    = w_ctrl.pc_sel;
    assign imm_sel   = w_ctrl.imm_sel;
    assign alu_src_a = w_ctrl.alu_src_a;
    assign alu_src_b = w_ctrl.alu_src_b;
    assign alu_op    = w_ctrl.alu_op;
    assign rf_we     = w_ctrl.rf_we;
    assign wb_sel    = w_ctrl.wb_sel;
    assign trap      = w_ctrl.trap;
    assign instret   = r_instret;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Directed bench for multicycle_ctrl. All control outputs are packed into one
// 19-bit word and compared each cycle against hand-built expected words.
// Word layout (msb..lsb): mem_req mem_we addr_sel ir_we pc_we pc_sel[1:0]
// imm_sel[2:0] alu_src_a[1:0] alu_src_b alu_op[1:0] rf_we wb_sel[1:0] trap
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    localparam logic [31:0] RESET_CNT = 32'd0;

    // Single-bit fields of the control word
    localparam logic [18:0] TRP  = 19'h00001;
    localparam logic [18:0] RFWE = 19'h00008;
    localparam logic [18:0] BIMM = 19'h00040;
    localparam logic [18:0] PCWE = 19'h04000;
    localparam logic [18:0] IRWE = 19'h08000;
    localparam logic [18:0] ASEL = 19'h10000;
    localparam logic [18:0] MWE  = 19'h20000;
    localparam logic [18:0] MREQ = 19'h40000;
    localparam logic [18:0] NONE = 19'h00000;

    // Instructions under test
    localparam logic [31:0] I_ADDI = 32'h0050_0093;  // addi x1,x0,5
    localparam logic [31:0] I_SW   = 32'h0020_A423;  // sw   x2,8(x1)
    localparam logic [31:0] I_BEQ  = 32'h0020_8463;  // beq  x1,x2,+8
    localparam logic [31:0] I_JALR = 32'h0000_80E7;  // jalr x1,0(x1)
    localparam logic [31:0] I_LUI  = 32'h1234_50B7;  // lui  x1,0x12345
    localparam logic [31:0] I_JAL  = 32'h0100_00EF;  // jal  x1,+16
    localparam logic [31:0] I_LW   = 32'h0040_A183;  // lw   x3,4(x1)
    localparam logic [31:0] I_BAD  = 32'h0000_007F;  // unknown opcode

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        mem_ready;
    logic        br_taken;
    logic        mem_req, mem_we, addr_sel, ir_we, pc_we;
    logic [1:0]  pc_sel;
    logic [2:0]  imm_sel;
    logic [1:0]  alu_src_a;
    logic        alu_src_b;
    logic [1:0]  alu_op;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        trap;
    logic [31:0] instret;

    logic [18:0] obs_w;
    int          n_checks;
    int          n_fail;

    multicycle_ctrl #(
        .TIMEOUT   (16),
        .RESET_CNT (RESET_CNT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .instr     (instr),
        .mem_ready (mem_ready),
        .br_taken  (br_taken),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .addr_sel  (addr_sel),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .pc_sel    (pc_sel),
        .imm_sel   (imm_sel),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .alu_op    (alu_op),
        .rf_we     (rf_we),
        .wb_sel    (wb_sel),
        .trap      (trap),
        .instret   (instret)
    );

    assign obs_w = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, imm_sel,
                    alu_src_a, alu_src_b, alu_op, rf_we, wb_sel, trap};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multi-bit field helpers for building expected words
    function automatic logic [18:0] f_pcs(input logic [1:0] v); return 19'(v) << 12; endfunction
    function automatic logic [18:0] f_imm(input logic [2:0] v); return 19'(v) << 9;  endfunction
    function automatic logic [18:0] f_a  (input logic [1:0] v); return 19'(v) << 7;  endfunction
    function automatic logic [18:0] f_op (input logic [1:0] v); return 19'(v) << 4;  endfunction
    function automatic logic [18:0] f_wb (input logic [1:0] v); return 19'(v) << 1;  endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: inputs are already driven; compare outputs mid-cycle,
    // then return just after the next rising edge.
    task automatic cyc(input string tag, input logic [18:0] exp_w);
        @(negedge clk);
        check(tag, {13'd0, obs_w}, {13'd0, exp_w});
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        instr     = 32'd0;
        mem_ready = 1'b0;
        br_taken  = 1'b0;

        // ---------------- reset
        @(posedge clk);
        #1;
        cyc("reset_cycle", NONE);
        check("instret_reset", instret, RESET_CNT);
        rst = 1'b0;
        cyc("first_fetch", MREQ);

        // ---------------- ADDI, zero wait: F D E WB
        instr = I_ADDI; mem_ready = 1'b1;
        cyc("addi_fetch", MREQ | IRWE);
        cyc("addi_decode", f_imm(3'b000));
        cyc("addi_exec", BIMM | f_op(2'b01));
        cyc("addi_wb", PCWE | RFWE | BIMM | f_op(2'b01) | f_wb(2'b00));
        check("addi_instret", instret, 32'd1);

        // ---------------- SW with three MEM wait states
        instr = I_SW;
        cyc("sw_fetch", MREQ | IRWE);
        cyc("sw_decode", f_imm(3'b001));
        cyc("sw_exec", f_imm(3'b001) | BIMM);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc("sw_mem_wait", MREQ | MWE | ASEL | f_imm(3'b001) | BIMM);
        end
        mem_ready = 1'b1;
        cyc("sw_mem_done", MREQ | MWE | ASEL | PCWE | f_pcs(2'b00) | f_imm(3'b001) | BIMM);
        check("sw_instret", instret, 32'd2);

        // ---------------- BEQ taken, then not taken: F D E
        instr = I_BEQ; br_taken = 1'b1;
        cyc("beq_t_fetch", MREQ | IRWE);
        cyc("beq_t_decode", f_imm(3'b010));
        cyc("beq_t_exec", PCWE | f_pcs(2'b01) | f_imm(3'b010) | f_op(2'b10));
        check("beq_t_instret", instret, 32'd3);
        br_taken = 1'b0;
        cyc("beq_n_fetch", MREQ | IRWE);
        cyc("beq_n_decode", f_imm(3'b010));
        cyc("beq_n_exec", PCWE | f_pcs(2'b00) | f_imm(3'b010) | f_op(2'b10));
        check("beq_n_instret", instret, 32'd4);

        // ---------------- JALR
        instr = I_JALR;
        cyc("jalr_fetch", MREQ | IRWE);
        cyc("jalr_decode", f_imm(3'b000));
        cyc("jalr_exec", BIMM | f_a(2'b00) | f_op(2'b00));
        cyc("jalr_wb", PCWE | f_pcs(2'b10) | BIMM | RFWE | f_wb(2'b10));
        check("jalr_instret", instret, 32'd5);

        // ---------------- LUI
        instr = I_LUI;
        cyc("lui_fetch", MREQ | IRWE);
        cyc("lui_decode", f_imm(3'b011));
        cyc("lui_exec", f_imm(3'b011) | f_a(2'b10) | BIMM);
        cyc("lui_wb", PCWE | f_imm(3'b011) | f_a(2'b10) | BIMM | RFWE);
        check("lui_instret", instret, 32'd6);

        // ---------------- JAL
        instr = I_JAL;
        cyc("jal_fetch", MREQ | IRWE);
        cyc("jal_decode", f_imm(3'b100));
        cyc("jal_exec", f_imm(3'b100) | f_a(2'b01) | BIMM);
        cyc("jal_wb", PCWE | f_pcs(2'b01) | f_imm(3'b100) | f_a(2'b01) | BIMM | RFWE | f_wb(2'b10));
        check("jal_instret", instret, 32'd7);

        // ---------------- LW, zero wait: F D E M WB
        instr = I_LW;
        cyc("lw_fetch", MREQ | IRWE);
        cyc("lw_decode", f_imm(3'b000));
        cyc("lw_exec", BIMM);
        cyc("lw_mem", MREQ | ASEL | BIMM);
        check("lw_no_retire_in_mem", instret, 32'd7);
        cyc("lw_wb", PCWE | BIMM | RFWE | f_wb(2'b01));
        check("lw_instret", instret, 32'd8);

        // ---------------- FETCH timeout: 16 unanswered cycles, then TRAP
        mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cyc("timeout_fetch", MREQ);
        end
        cyc("timeout_trap", TRP);
        mem_ready = 1'b1;
        cyc("trap_held_ready", TRP);
        cyc("trap_held", TRP);
        check("trap_instret", instret, 32'd8);
        rst = 1'b1;
        cyc("trap_reset_cycle", NONE);
        rst = 1'b0; mem_ready = 1'b0;
        check("trap_reset_instret", instret, RESET_CNT);
        cyc("trap_recover_fetch", MREQ);

        // ---------------- illegal opcode
        instr = I_BAD; mem_ready = 1'b1;
        cyc("bad_fetch", MREQ | IRWE);
        cyc("bad_decode", NONE);
        cyc("bad_trap", TRP);
        cyc("bad_trap_held", TRP);
        check("bad_instret", instret, RESET_CNT);
        rst = 1'b1;
        cyc("bad_reset_cycle", NONE);
        rst = 1'b0;

        // ---------------- reset in the middle of a waiting LOAD MEM cycle
        instr = I_LW; mem_ready = 1'b1;
        cyc("lwr_fetch", MREQ | IRWE);
        cyc("lwr_decode", f_imm(3'b000));
        cyc("lwr_exec", BIMM);
        mem_ready = 1'b0;
        cyc("lwr_mem_wait", MREQ | ASEL | BIMM);
        rst = 1'b1;
        cyc("lwr_reset_cycle", NONE);
        rst = 1'b0;
        cyc("lwr_after_reset", MREQ);
        check("lwr_instret", instret, RESET_CNT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
